ibus_line_cache: RTL and testbench

IBUS_LINE_CACHE -- requirements
Module: ibus_line_cache

---
 rtl/ibus_line_cache_if.sv | 68 ++++++
 rtl/ibus_line_cache.sv | 162 ++++++++++++++++
 tb/tb_ibus_line_cache.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibus_line_cache_if.sv
// Instruction-bus line cache: shared bus types and the port bundle.
//
// ibus_line_cache_pkg
//   cbus_req_t  : downstream request (valid, is_write, size, addr, strobe,
//                 data, len, burst). len counts beats minus one.
//   cbus_resp_t : downstream response (ready, last, data).
//
// ibus_line_cache_if
//   ireq_valid / ireq_addr       : fetch request from the core
//   iresp_data_ok / iresp_data   : fetch response to the core
//   flush                        : invalidate all lines (fence.i)
//   oreq / oresp                 : downstream memory bus
//   modport slave  : the cache's view
//   modport master : the environment's view (core side + memory side)

package ibus_line_cache_pkg;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    localparam logic [7:0] MLEN1 = 8'd0;
    localparam logic [7:0] MLEN8 = 8'd7;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

interface ibus_line_cache_if;
    import ibus_line_cache_pkg::*;

    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [63:0] iresp_data;
    logic        flush;
    cbus_req_t   oreq;
    cbus_resp_t  oresp;

    modport slave (
        input  ireq_valid, ireq_addr, flush, oresp,
        output iresp_data_ok, iresp_data, oreq
    );

    modport master (
        output ireq_valid, ireq_addr, flush, oresp,
        input  iresp_data_ok, iresp_data, oreq
    );
endinterface

// File: rtl/ibus_line_cache.sv
// Direct-mapped, read-only instruction line cache (64-byte lines).
// Cacheable hits answer combinationally in the same cycle; misses refill a
// whole line with an 8-beat INCR burst; addresses with bit 31 clear bypass
// the cache with a single-beat FIXED read.
//
// Ports
//   clk    : clock
//   reset  : synchronous, active-low
//   bus    : ibus_line_cache_if.slave (fetch request/response, flush,
//            downstream oreq/oresp)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a fetch; hits answered here
// REFILL   | line burst in flight, beats written as they arrive
// UNCACHED | single-beat bypass read in flight
// RESP     | one-cycle response from the refilled line or holding register

module ibus_line_cache
    import ibus_line_cache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WORDS = 8
) (
    input  logic clk,
    input  logic reset,
    ibus_line_cache_if.slave bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 64 - 6 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, UNCACHED, RESP} state_t;

    state_t state_q, state_d;

    logic [63:0]      data_mem [SETS][WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid_q;
    logic [63:0]      req_addr_q;
    logic [63:0]      hold_q;
    logic [2:0]       beat_q;
    logic             fill_killed_q;

    logic [IDX_W-1:0] in_idx, req_idx;
    logic [TAG_W-1:0] in_tag, req_tag;
    logic [2:0]       in_word, req_word;
    logic             in_cacheable, req_cacheable;
    logic             hit, beat_last;

    logic             resp_ok;
    logic [63:0]      resp_word;
    cbus_req_t        req;

    assign in_idx        = bus.ireq_addr[6+IDX_W-1:6];
    assign in_tag        = bus.ireq_addr[63:6+IDX_W];
    assign in_word       = bus.ireq_addr[5:3];
    assign in_cacheable  = bus.ireq_addr[31];
    assign req_idx       = req_addr_q[6+IDX_W-1:6];
    assign req_tag       = req_addr_q[63:6+IDX_W];
    assign req_word      = req_addr_q[5:3];
    assign req_cacheable = req_addr_q[31];

    assign hit       = in_cacheable && valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
    assign beat_last = bus.oresp.ready && bus.oresp.last;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        resp_ok   = 1'b0;
        resp_word = '0;
        req       = '0;
        case (state_q)
            IDLE: begin
                if (bus.ireq_valid) begin
                    if (!in_cacheable) begin
                        state_d = UNCACHED;
                    end else if (hit) begin
                        resp_ok   = 1'b1;
                        resp_word = data_mem[in_idx][in_word];
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                req.valid = 1'b1;
                req.size  = MSIZE8;
                req.addr  = {req_addr_q[63:6], 6'b0};
                req.len   = MLEN8;
                req.burst = AXI_BURST_INCR;
                if (beat_last) state_d = RESP;
            end
            UNCACHED: begin
                req.valid = 1'b1;
                req.size  = MSIZE8;
                req.addr  = req_addr_q;
                req.len   = MLEN1;
                req.burst = AXI_BURST_FIXED;
                if (beat_last) state_d = RESP;
            end
            RESP: begin
                resp_ok   = bus.ireq_valid;
                resp_word = req_cacheable ? data_mem[req_idx][req_word] : hold_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset forces quiet outputs even before the state register settles.
        if (!reset) begin
            state_d   = IDLE;
            resp_ok   = 1'b0;
            resp_word = '0;
            req       = '0;
        end
    end

    assign bus.oreq          = req;
    assign bus.iresp_data_ok = resp_ok;
    assign bus.iresp_data    = resp_ok ? resp_word : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q       <= '0;
            req_addr_q    <= '0;
            hold_q        <= '0;
            beat_q        <= '0;
            fill_killed_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.ireq_valid && !hit) begin
                req_addr_q    <= bus.ireq_addr;
                fill_killed_q <= 1'b0;
            end
            if (state_q == REFILL && bus.oresp.ready) begin
                beat_q <= beat_q + 3'd1;
                if (bus.oresp.last) begin
                    beat_q <= '0;
                    if (!fill_killed_q) valid_q[req_idx] <= 1'b1;
                end
            end
            if (state_q == UNCACHED && beat_last) hold_q <= bus.oresp.data;
            // Placed last so a flush wins over a line commit in the same cycle;
            // a flush during a refill also keeps that line from ever going valid.
            if (bus.flush) begin
                valid_q <= '0;
                if (state_q == REFILL) fill_killed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == REFILL && bus.oresp.ready) begin
            data_mem[req_idx][beat_q] <= bus.oresp.data;
            if (bus.oresp.last) tag_mem[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_ibus_line_cache.sv
// Self-checking bench for ibus_line_cache: directed scenarios plus a
// randomized fetch stream, all compared against a set-indexed line model.
module tb_ibus_line_cache;
    import ibus_line_cache_pkg::*;

    localparam int SETS = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ibus_line_cache_if bus();

    ibus_line_cache #(.SETS(SETS), .WORDS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    bit          m_valid [SETS];
    logic [63:0] m_line  [SETS];
    logic [63:0] m_data  [SETS][8];

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_1234 ^ a[63:32], ~a[31:0]};
    endfunction

    function automatic int set_of(input logic [63:0] a);
        return int'(a[9:6]);
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:6], 6'b0};
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    endfunction

    function automatic void predict(input logic [63:0] a, input bit beat_idx,
                                    output bit hit, output logic [63:0] d,
                                    output cbus_req_t req);
        int s = set_of(a);
        int w = int'(a[5:3]);
        req = '0;
        hit = 1'b0;
        if (!a[31]) begin
            d = mem_word(a);
            req.valid = 1'b1; req.size = MSIZE8; req.addr = a;
            req.len = MLEN1; req.burst = AXI_BURST_FIXED;
        end else if (m_valid[s] && m_line[s] == line_of(a)) begin
            hit = 1'b1;
            d = m_data[s][w];
        end else begin
            d = beat_idx ? 64'(w) : mem_word(line_of(a) + 64'(w * 8));
            req.valid = 1'b1; req.size = MSIZE8; req.addr = line_of(a);
            req.len = MLEN8; req.burst = AXI_BURST_INCR;
        end
    endfunction

    function automatic void commit(input logic [63:0] a, input bit beat_idx, input bit was_hit);
        int s = set_of(a);
        if (was_hit || !a[31]) return;
        m_valid[s] = 1'b1;
        m_line[s]  = line_of(a);
        for (int w = 0; w < 8; w++)
            m_data[s][w] = beat_idx ? 64'(w) : mem_word(line_of(a) + 64'(w * 8));
    endfunction

    // Drives one fetch and plays the memory side. flush_beat >= 0 raises flush
    // once while that beat is pending; flush_first raises it with the request.
    task automatic fetch(input logic [63:0] a, input bit beat_idx, input int flush_beat,
                         input bit flush_first, output bit got, output logic [63:0] d,
                         output int lat, output int nreq, output cbus_req_t first,
                         output bit bus_ok, output bit flushed);
        int beat = 0;
        bit in_burst = 1'b0;
        bit rdy, lst;
        got = 1'b0; d = '0; lat = -1; nreq = 0; first = '0; bus_ok = 1'b1;
        flushed = flush_first;
        @(negedge clk);
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = a;
        bus.flush      = flush_first;
        for (int cyc = 0; cyc < 300 && !got; cyc++) begin
            #1;
            rdy = 1'b0; lst = 1'b0;
            if (bus.iresp_data_ok) begin
                got = 1'b1; d = bus.iresp_data; lat = cyc;
            end
            if (bus.oreq.valid) begin
                if (!in_burst) begin
                    in_burst = 1'b1; nreq++; first = bus.oreq;
                end else if (bus.oreq !== first) begin
                    bus_ok = 1'b0;
                end
                if (flush_beat >= 0 && !flushed && beat == flush_beat) begin
                    bus.flush = 1'b1; flushed = 1'b1;
                end
                rdy = ($urandom_range(0, 3) != 0);
                lst = rdy && (beat == int'(bus.oreq.len));
                bus.oresp.ready = rdy;
                bus.oresp.last  = lst;
                bus.oresp.data  = beat_idx ? 64'(beat) :
                    mem_word(bus.oreq.burst == AXI_BURST_INCR ? bus.oreq.addr + 64'(beat * 8)
                                                             : bus.oreq.addr);
            end
            @(posedge clk);
            if (rdy) begin
                if (lst) begin beat = 0; in_burst = 1'b0; end
                else beat++;
            end
            @(negedge clk);
            bus.oresp = '0;
            bus.flush = 1'b0;
        end
        bus.ireq_valid = 1'b0;
    endtask

    // Runs a list of fetches, checking data, hit/miss timing and the bus request.
    task automatic run_list(input string name, input logic [63:0] addrs[$], input bit beat_idx,
                            input int fbeats[$], input bit ffirst[$]);
        bit eh, got, bok, fl;
        logic [63:0] ed, d;
        cbus_req_t er, first;
        int lat, nreq;
        for (int i = 0; i < addrs.size(); i++) begin
            predict(addrs[i], beat_idx, eh, ed, er);
            fetch(addrs[i], beat_idx, fbeats[i], ffirst[i], got, d, lat, nreq, first, bok, fl);
            tests++;
            if (!got || d !== ed) begin
                fails++;
                $display("FAIL %s[%0d] data: got ok=%0b data=%h, expected %h", name, i, got, d, ed);
            end
            tests++;
            if ((lat == 0) != eh || nreq != (eh ? 0 : 1)) begin
                fails++;
                $display("FAIL %s[%0d] hit: latency %0d reqs %0d, expected hit=%0b", name, i, lat, nreq, eh);
            end
            if (!eh) begin
                tests++;
                if (first !== er || !bok) begin
                    fails++;
                    $display("FAIL %s[%0d] oreq: got %h held=%0b, expected %h", name, i, first, bok, er);
                end
            end
            commit(addrs[i], beat_idx, eh);
            if (fl) model_clear();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h8000_0048;
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 64'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests++;
            if ({bus.oreq, bus.iresp_data_ok, bus.iresp_data} !== '0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: oreq=%h ok=%0b data=%h, expected all 0",
                         i, bus.oreq, bus.iresp_data_ok, bus.iresp_data);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        bus.oresp = '0;
        #1;
        tests++;
        if ({bus.oreq, bus.iresp_data_ok, bus.iresp_data} !== '0) begin
            fails++;
            $display("FAIL reset_after: oreq=%h ok=%0b data=%h, expected all 0",
                     bus.oreq, bus.iresp_data_ok, bus.iresp_data);
        end
        bus.ireq_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss_and_hit();
        run_list("cold_miss", '{64'h8000_0048}, 1'b1, '{-1}, '{1'b0});
        run_list("hit", '{64'h8000_0078, 64'h8000_0040}, 1'b1, '{-1, -1}, '{1'b0, 1'b0});
    endtask

    task automatic test_conflict();
        run_list("conflict", '{64'h8000_0040, 64'h8000_0440, 64'h8000_0040}, 1'b0,
                 '{-1, -1, -1}, '{1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_uncached();
        run_list("uncached", '{64'h1000_0008, 64'h1000_0008}, 1'b0, '{-1, -1}, '{1'b0, 1'b0});
    endtask

    task automatic test_flush_mid_refill();
        run_list("flush_refill", '{64'h8000_0100, 64'h8000_0100, 64'h8000_0108, 64'h8000_0040},
                 1'b0, '{4, -1, -1, -1}, '{1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_flush_with_hit();
        run_list("flush_hit", '{64'h8000_0100, 64'h8000_0100},
                 1'b0, '{-1, -1}, '{1'b1, 1'b0});
    endtask

    task automatic test_reset_mid_refill();
        logic [63:0] a = 64'h8000_0200;
        int beats = 0;
        bit rdy;
        run_list("pre_reset", '{a}, 1'b0, '{-1}, '{1'b0});
        @(negedge clk);
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h8000_0600;
        for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
            #1;
            rdy = bus.oreq.valid;
            bus.oresp = '{ready: rdy, last: 1'b0, data: 64'hBAD0_0000 + 64'(beats)};
            @(posedge clk);
            if (rdy) beats++;
            @(negedge clk);
            bus.oresp = '0;
        end
        tests++;
        if (beats != 3) begin
            fails++;
            $display("FAIL reset_refill_start: got %0d beats, expected 3", beats);
        end
        reset = 1'b0;
        bus.ireq_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (bus.oreq.valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_refill_abandon: oreq.valid=%0b, expected 0", bus.oreq.valid);
        end
        model_clear();
        run_list("post_reset", '{64'h8000_0600, a}, 1'b0, '{-1, -1}, '{1'b0, 1'b0});
    endtask

    task automatic test_random();
        logic [63:0] a;
        bit f;
        int fb;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0)
                a = 64'h1000_0000 + 64'($urandom_range(0, 31)) * 8;
            else
                a = 64'h8000_0000 + 64'($urandom_range(0, 3)) * 64'h400
                                  + 64'($urandom_range(0, 127)) * 8;
            f = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            bus.ireq_addr = a;
            bus.flush     = f;
            #1;
            tests++;
            if (bus.iresp_data_ok !== 1'b0 || bus.iresp_data !== '0 || bus.oreq.valid !== 1'b0) begin
                fails++;
                $display("FAIL idle_quiet[%0d]: ok=%0b data=%h oreq.valid=%0b, expected 0",
                         i, bus.iresp_data_ok, bus.iresp_data, bus.oreq.valid);
            end
            if (f) model_clear();
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_list("random", '{a}, 1'b0, '{fb}, '{1'b0});
        end
    endtask

    initial begin
        bus.ireq_valid = 1'b0;
        bus.ireq_addr  = '0;
        bus.flush      = 1'b0;
        bus.oresp      = '0;
        reset          = 1'b0;
        model_clear();
        test_reset();
        test_cold_miss_and_hit();
        test_conflict();
        test_uncached();
        test_flush_mid_refill();
        test_flush_with_hit();
        test_reset_mid_refill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
